// File: rtl/fc_pkg.sv
// Shared types and sizing for the fully-connected layer blocks.
package fc_pkg;

  localparam int PREC        = 18;   // fixed-point word width
  localparam int FC0_FAN_IN  = 784;  // fc0 inputs per image (even)
  localparam int FC0_NEURONS = 98;   // fc0 neurons; replay bus carries 2x this many lanes
  localparam int FC0_ID_W    = 10;   // b_activation_id width, 2^ID_W >= FAN_IN

  typedef logic signed [PREC-1:0] act_t;
  typedef act_t [1:0]             act_pair_t;  // [1] = x[2k+1], [0] = x[2k]

  typedef enum logic [2:0] {
    BP_IDLE,
    BP_CAPTURE,
    BP_LOADED,
    BP_REPLAY,
    BP_DONE
  } bp_feed_state_e;

endpackage

// File: rtl/fc_act_buffer_ram.sv
// Simple dual-port activation buffer: one write port, one registered read port.
module fc_act_buffer_ram
  import fc_pkg::*;
#(
  parameter int DEPTH = FC0_FAN_IN / 2,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_addr_i,
  input  act_pair_t     wr_data_i,
  input  logic          rd_en_i,
  input  logic [AW-1:0] rd_addr_i,
  output act_pair_t     rd_data_o
);

  act_pair_t mem_q [DEPTH];
  act_pair_t rd_data_q;

  // Write port and 1-cycle registered read port.
  // NOTE: the array and read register have no reset so the tools map them onto block RAM;
  // sequential state always uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
    if (rd_en_i) rd_data_q <= mem_q[rd_addr_i];
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/fc0_bp_feeder.sv
// Captures the fc0 forward input stream and replays it, with a latched gradient, for backprop.
module fc0_bp_feeder
  import fc_pkg::*;
#(
  parameter int FAN_IN  = FC0_FAN_IN,
  parameter int NEURONS = FC0_NEURONS,
  parameter int ID_W    = FC0_ID_W
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      valid_i,
  input  logic [2*PREC-1:0]         activations_i,
  input  logic                      start_bp,
  input  logic [NEURONS*PREC-1:0]   b_gradient_i,
  output logic                      captured_o,
  output logic [2*NEURONS*PREC-1:0] b_activation_o,
  output logic [ID_W-1:0]           b_activation_id,
  output logic [NEURONS*PREC-1:0]   b_gradient_o,
  output logic                      b_valid_o,
  output logic                      b_last_o,
  output logic                      bp_done_o,
  output logic                      overrun_o
);

  localparam int            DEPTH     = FAN_IN / 2;
  localparam int            AW        = $clog2(DEPTH);
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  logic [1:0] rst_sync_q;
  logic       rst_int_n;

  bp_feed_state_e          state_q, state_d;
  logic [AW-1:0]           wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]           rd_ptr_q, rd_ptr_d;
  logic                    captured_q, captured_d;
  logic                    overrun_q, overrun_d;
  logic [NEURONS*PREC-1:0] grad_q, grad_d;

  logic          start_ok, wr_en, rd_en, rd_last;
  logic [AW-1:0] rd_addr;
  act_pair_t     ram_rdata;

  logic            rd_valid_q, rd_last_q;
  logic [AW-1:0]   rd_idx_q;
  logic            b_valid_q, b_last_q, bp_done_q;
  logic [ID_W-1:0] b_id_q;
  act_pair_t       b_pair_q;

  // Reset synchroniser: asserts asynchronously, releases two clocks after rst_n rises.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync_q <= '0;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  assign rst_int_n = rst_sync_q[1];

  fc_act_buffer_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk       (clk),
    .wr_en_i   (wr_en),
    .wr_addr_i (wr_ptr_q),
    .wr_data_i (act_pair_t'(activations_i)),
    .rd_en_i   (rd_en),
    .rd_addr_i (rd_addr),
    .rd_data_o (ram_rdata)
  );

  // Next-state, pointer, flag and RAM-port decode.
  // NOTE: every signal gets a default before the case so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    grad_d    = grad_q;
    overrun_d = overrun_q;
    start_ok  = 1'b0;
    wr_en     = 1'b0;
    rd_en     = 1'b0;
    rd_addr   = rd_ptr_q;
    case (state_q)
      BP_IDLE, BP_CAPTURE, BP_LOADED: begin
        start_ok = (state_q == BP_LOADED) && start_bp;
        if (start_ok) begin
          // Entry 0 is read in the start cycle so the first beat lands two cycles later.
          grad_d   = b_gradient_i;
          rd_en    = 1'b1;
          rd_addr  = '0;
          rd_ptr_d = AW'(1);
          state_d  = BP_REPLAY;
          if (valid_i) overrun_d = 1'b1;
        end else if (valid_i) begin
          // wr_ptr_q is 0 in IDLE and LOADED, so a beat there starts a new image.
          wr_en = 1'b1;
          if (wr_ptr_q == LAST_ADDR) begin
            wr_ptr_d = '0;
            state_d  = BP_LOADED;
          end else begin
            wr_ptr_d = wr_ptr_q + 1'b1;
            state_d  = BP_CAPTURE;
          end
        end
      end
      BP_REPLAY: begin
        rd_en = 1'b1;
        if (valid_i) overrun_d = 1'b1;
        if (rd_ptr_q == LAST_ADDR) begin
          rd_ptr_d = '0;
          state_d  = BP_DONE;
        end else begin
          rd_ptr_d = rd_ptr_q + 1'b1;
        end
      end
      BP_DONE: begin
        if (valid_i)  overrun_d = 1'b1;
        if (b_last_q) state_d   = BP_LOADED;  // bp_done_o pulses as LOADED is entered
      end
      default: state_d = BP_IDLE;
    endcase
    rd_last    = rd_en && (rd_addr == LAST_ADDR);
    captured_d = (state_d == BP_LOADED) || (state_d == BP_REPLAY) || (state_d == BP_DONE);
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_q    <= BP_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      captured_q <= 1'b0;
      overrun_q  <= 1'b0;
      grad_q     <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      captured_q <= captured_d;
      overrun_q  <= overrun_d;
      grad_q     <= grad_d;
    end
  end

  // Read pipeline: RAM-stage tags, then the output register that holds data between beats.
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
      rd_idx_q   <= '0;
      b_valid_q  <= 1'b0;
      b_last_q   <= 1'b0;
      bp_done_q  <= 1'b0;
      b_id_q     <= '0;
      b_pair_q   <= '0;
    end else begin
      rd_valid_q <= rd_en;
      rd_last_q  <= rd_last;
      rd_idx_q   <= rd_addr;
      b_valid_q  <= rd_valid_q;
      b_last_q   <= rd_valid_q && rd_last_q;
      bp_done_q  <= b_last_q;
      if (rd_valid_q) begin
        b_pair_q <= ram_rdata;
        b_id_q   <= ID_W'({rd_idx_q, 1'b0});
      end
    end
  end

  // Fan the stored pair out: even inputs on lanes 0..N-1, odd inputs on lanes N..2N-1.
  for (genvar n = 0; n < NEURONS; n++) begin : g_lane
    assign b_activation_o[n*PREC +: PREC]           = b_pair_q[0];
    assign b_activation_o[(n+NEURONS)*PREC +: PREC] = b_pair_q[1];
  end

  assign captured_o      = captured_q;
  assign b_activation_id = b_id_q;
  assign b_gradient_o    = grad_q;
  assign b_valid_o       = b_valid_q;
  assign b_last_o        = b_last_q;
  assign bp_done_o       = bp_done_q;
  assign overrun_o       = overrun_q;

endmodule
